risc_ctrl_fsm: RTL and testbench

//  Parametrised multi-cycle control unit for the RISC SPM datapath.

---
 rtl/risc_spm_pkg.sv | 51 +++++
 rtl/risc_ctrl_fsm_if.sv | 50 +++++
 rtl/risc_ctrl_fsm_io_wait_timer.sv | 42 ++++
 rtl/risc_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_risc_ctrl_fsm.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_spm_pkg.sv
// ---------------------------------------------------------------------------
// risc_spm_pkg
// Shared definitions for the RISC SPM control unit: opcode values, the
// controller state encoding, BUS2 multiplexer select codes and the helper
// that decodes the address-space bit of a register field.
// ---------------------------------------------------------------------------
package risc_spm_pkg;

    // Opcodes (instr[WORD_SZ-1 -: OP_SZ]); anything not listed is illegal.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_RD  = 4'h5;
    localparam logic [3:0] OP_WR  = 4'h6;
    localparam logic [3:0] OP_BR  = 4'h7;
    localparam logic [3:0] OP_BRZ = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Controller states, 4-bit encoding.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_e;

    // BUS2 multiplexer select codes.
    localparam logic [1:0] BUS2_ALU  = 2'd0;
    localparam logic [1:0] BUS2_BUS1 = 2'd1;
    localparam logic [1:0] BUS2_MEM  = 2'd2;
    localparam logic [1:0] BUS2_IO   = 2'd3;

    // The MSB of a register field selects the address space of RD/WR.
    localparam logic SPACE_MEM = 1'b0;
    localparam logic SPACE_IO  = 1'b1;

    function automatic logic is_io(input logic space_bit);
        return space_bit == SPACE_IO;
    endfunction

endpackage

// File: rtl/risc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// risc_ctrl_fsm_if
// Bundle between the control unit and the datapath / memory / I/O side.
//   instr, zero, io_ack          : datapath -> controller
//   load_reg, bus1_sel, bus2_sel : register load strobes and bus selects
//   load_pc .. load_reg_z        : datapath strobes
//   mem_write, io_req, io_write  : memory / I/O access controls
//   halted, err                  : status
// master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface risc_ctrl_fsm_if #(
    parameter int WORD_SZ = 8,
    parameter int FLD_SZ  = 2
);
    localparam int NREG  = 2**FLD_SZ;
    localparam int SEL_W = $clog2(NREG + 1);

    logic [WORD_SZ-1:0] instr;
    logic               zero;
    logic               io_ack;
    logic [NREG-1:0]    load_reg;
    logic [SEL_W-1:0]   bus1_sel;
    logic [1:0]         bus2_sel;
    logic               load_pc;
    logic               inc_pc;
    logic               load_ir;
    logic               load_add_r;
    logic               load_reg_y;
    logic               load_reg_z;
    logic               mem_write;
    logic               io_req;
    logic               io_write;
    logic               halted;
    logic               err;

    modport master (
        input  instr, zero, io_ack,
        output load_reg, bus1_sel, bus2_sel, load_pc, inc_pc, load_ir,
               load_add_r, load_reg_y, load_reg_z, mem_write, io_req,
               io_write, halted, err
    );

    modport slave (
        output instr, zero, io_ack,
        input  load_reg, bus1_sel, bus2_sel, load_pc, inc_pc, load_ir,
               load_add_r, load_reg_y, load_reg_z, mem_write, io_req,
               io_write, halted, err
    );

endinterface

// File: rtl/risc_ctrl_fsm_io_wait_timer.sv
// ---------------------------------------------------------------------------
// io_wait_timer
// Counts I/O wait cycles of one access and flags the cycle in which the
// wait budget runs out.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart the count (access about to begin)
//   en       : an I/O wait cycle without acknowledge
//   expired  : this cycle is the last allowed wait cycle (IO_TIMEOUT != 0)
// IO_TIMEOUT = 0 disables expiry; the counter then just wraps unobserved.
// ---------------------------------------------------------------------------
module io_wait_timer #(
    parameter int IO_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int                CNT_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'((IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expired = (IO_TIMEOUT != 0) && en && (count_q == LAST);

endmodule

// File: rtl/risc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// risc_ctrl_fsm
// Multi-cycle control unit for the RISC SPM datapath. Fetches and decodes
// the IR, sequences register loads and bus selects, and runs RD/WR accesses
// to either memory or an I/O space with a req/ack wait-state handshake.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : risc_ctrl_fsm_if.master (instr/zero/io_ack in, controls out)
// Only the state and the sticky err flag are registered; every other output
// is decoded from the current state, instr, zero and io_ack, so a reset
// drops io_req immediately.
// ---------------------------------------------------------------------------
module risc_ctrl_fsm
    import risc_spm_pkg::*;
#(
    parameter int WORD_SZ    = 8,
    parameter int OP_SZ      = 4,
    parameter int FLD_SZ     = 2,
    parameter int IO_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    risc_ctrl_fsm_if.master bus
);
    localparam int               NREG   = 2**FLD_SZ;
    localparam int               SEL_W  = $clog2(NREG + 1);
    localparam logic [SEL_W-1:0] SEL_PC = SEL_W'(NREG);

    state_e state_q, state_d;
    logic   err_q, err_d;

    logic [OP_SZ-1:0]  opcode;
    logic [FLD_SZ-1:0] src, dst;
    logic [NREG-1:0]   dst_onehot;
    logic              rd_io, wr_io, io_wait;
    logic              timer_clr, timer_en, timer_expired;

    assign opcode     = bus.instr[WORD_SZ-1 -: OP_SZ];
    assign src        = bus.instr[2*FLD_SZ-1 -: FLD_SZ];
    assign dst        = bus.instr[FLD_SZ-1:0];
    assign dst_onehot = NREG'(1) << dst;

    // RD picks its space from the source field, WR from the destination field.
    assign rd_io   = is_io(src[FLD_SZ-1]);
    assign wr_io   = is_io(dst[FLD_SZ-1]);
    assign io_wait = ((state_q == S_RD2) && rd_io) || ((state_q == S_WR2) && wr_io);

    // RD1/WR1 are the only ways into RD2/WR2, so clearing there restarts
    // the count for every access.
    assign timer_clr = (state_q == S_RD1) || (state_q == S_WR1);
    assign timer_en  = io_wait && !bus.io_ack;

    io_wait_timer #(.IO_TIMEOUT(IO_TIMEOUT)) u_io_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case statement leaves one unassigned (no latches).
        state_d        = state_q;
        err_d          = err_q;
        bus.load_reg   = '0;
        bus.bus1_sel   = '0;
        bus.bus2_sel   = BUS2_ALU;
        bus.load_pc    = 1'b0;
        bus.inc_pc     = 1'b0;
        bus.load_ir    = 1'b0;
        bus.load_add_r = 1'b0;
        bus.load_reg_y = 1'b0;
        bus.load_reg_z = 1'b0;
        bus.mem_write  = 1'b0;
        bus.io_req     = 1'b0;
        bus.io_write   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FET1;

            S_FET1: begin
                bus.bus1_sel   = SEL_PC;
                bus.bus2_sel   = BUS2_BUS1;
                bus.load_add_r = 1'b1;
                state_d        = S_FET2;
            end

            S_FET2: begin
                bus.bus2_sel = BUS2_MEM;
                bus.load_ir  = 1'b1;
                bus.inc_pc   = 1'b1;
                state_d      = S_DEC;
            end

            S_DEC: begin
                case (opcode)
                    OP_SZ'(OP_NOP): state_d = S_FET1;
                    OP_SZ'(OP_ADD), OP_SZ'(OP_SUB), OP_SZ'(OP_AND): begin
                        bus.bus1_sel   = SEL_W'(src);
                        bus.bus2_sel   = BUS2_BUS1;
                        bus.load_reg_y = 1'b1;
                        state_d        = S_EX1;
                    end
                    OP_SZ'(OP_NOT): begin
                        bus.bus1_sel   = SEL_W'(src);
                        bus.bus2_sel   = BUS2_ALU;
                        bus.load_reg   = dst_onehot;
                        bus.load_reg_z = 1'b1;
                        state_d        = S_FET1;
                    end
                    OP_SZ'(OP_RD), OP_SZ'(OP_WR), OP_SZ'(OP_BR), OP_SZ'(OP_BRZ): begin
                        if ((opcode == OP_SZ'(OP_BRZ)) && !bus.zero) begin
                            // Untaken branch: skip the address word.
                            bus.inc_pc = 1'b1;
                            state_d    = S_FET1;
                        end else begin
                            bus.bus1_sel   = SEL_PC;
                            bus.bus2_sel   = BUS2_BUS1;
                            bus.load_add_r = 1'b1;
                            if (opcode == OP_SZ'(OP_RD))
                                state_d = S_RD1;
                            else if (opcode == OP_SZ'(OP_WR))
                                state_d = S_WR1;
                            else
                                state_d = S_BR1;
                        end
                    end
                    OP_SZ'(OP_HLT): state_d = S_HALT;
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end

            S_EX1: begin
                bus.bus1_sel   = SEL_W'(dst);
                bus.bus2_sel   = BUS2_ALU;
                bus.load_reg   = dst_onehot;
                bus.load_reg_z = 1'b1;
                state_d        = S_FET1;
            end

            S_RD1, S_WR1: begin
                bus.bus2_sel   = BUS2_MEM;
                bus.load_add_r = 1'b1;
                bus.inc_pc     = 1'b1;
                state_d        = (state_q == S_RD1) ? S_RD2 : S_WR2;
            end

            S_BR1: begin
                bus.bus2_sel   = BUS2_MEM;
                bus.load_add_r = 1'b1;
                state_d        = S_BR2;
            end

            S_BR2: begin
                bus.bus2_sel = BUS2_MEM;
                bus.load_pc  = 1'b1;
                state_d      = S_FET1;
            end

            S_RD2: begin
                if (!rd_io) begin
                    bus.bus2_sel = BUS2_MEM;
                    bus.load_reg = dst_onehot;
                    state_d      = S_FET1;
                end else begin
                    bus.io_req   = 1'b1;
                    bus.bus2_sel = BUS2_IO;
                    // An ack in the expiry cycle still completes the read.
                    if (bus.io_ack) begin
                        bus.load_reg = dst_onehot;
                        state_d      = S_FET1;
                    end else if (timer_expired) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end

            S_WR2: begin
                bus.bus1_sel = SEL_W'(src);
                if (!wr_io) begin
                    bus.mem_write = 1'b1;
                    state_d       = S_FET1;
                end else begin
                    bus.io_req   = 1'b1;
                    bus.io_write = 1'b1;
                    if (bus.io_ack) begin
                        state_d = S_FET1;
                    end else if (timer_expired) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.halted = (state_q == S_HALT);
    assign bus.err    = err_q;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_risc_ctrl_fsm
// Instruction-level reference model: each instruction is expanded into the
// list of per-cycle control words it should produce, together with the
// io_ack pattern to apply, and the DUT is compared cycle by cycle.
// Directed instructions first, then randomized ones.
// ---------------------------------------------------------------------------
module tb_risc_ctrl_fsm;

    localparam int         IO_TIMEOUT = 16;
    localparam logic [2:0] B1_PC      = 3'd4;
    localparam logic [1:0] B2_ALU     = 2'd0;
    localparam logic [1:0] B2_BUS1    = 2'd1;
    localparam logic [1:0] B2_MEM     = 2'd2;
    localparam logic [1:0] B2_IO      = 2'd3;

    typedef struct packed {
        logic [3:0] load_reg;
        logic [2:0] bus1;
        logic [1:0] bus2;
        logic       load_pc;
        logic       inc_pc;
        logic       load_ir;
        logic       load_add_r;
        logic       load_reg_y;
        logic       load_reg_z;
        logic       mem_write;
        logic       io_req;
        logic       io_write;
        logic       halted;
        logic       err;
    } outs_t;

    typedef struct packed {
        outs_t      outs;
        logic       ack;
        logic       drive;
        logic [7:0] instr;
        logic       zero;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       zero = 1'b0;
    logic       io_ack = 1'b0;
    outs_t      act;

    risc_ctrl_fsm_if #(.WORD_SZ(8), .FLD_SZ(2)) ifc ();

    assign ifc.instr  = instr;
    assign ifc.zero   = zero;
    assign ifc.io_ack = io_ack;
    assign act = {ifc.load_reg, ifc.bus1_sel, ifc.bus2_sel, ifc.load_pc, ifc.inc_pc,
                  ifc.load_ir, ifc.load_add_r, ifc.load_reg_y, ifc.load_reg_z,
                  ifc.mem_write, ifc.io_req, ifc.io_write, ifc.halted, ifc.err};

    risc_ctrl_fsm #(
        .WORD_SZ    (8),
        .OP_SZ      (4),
        .FLD_SZ     (2),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic       m_err = 1'b0;
    logic       m_halted = 1'b0;
    logic [7:0] cur_instr = 8'h00;
    ent_t       exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic outs_t base();
        outs_t o;
        o        = '0;
        o.err    = m_err;
        o.halted = m_halted;
        return o;
    endfunction

    task automatic push(input outs_t o, input logic ack = 1'b0, input logic drive = 1'b0,
                        input logic [7:0] ins = 8'h00, input logic z = 1'b0);
        ent_t e;
        e.outs  = o;
        e.ack   = ack;
        e.drive = drive;
        e.instr = ins;
        e.zero  = z;
        exp_q.push_back(e);
    endtask

    // I/O wait: ack arrives after dly wait cycles; no ack within the
    // IO_TIMEOUT budget ends in error + halt.
    task automatic io_phase(input outs_t o_wait, input outs_t o_done, input int dly);
        for (int k = 0; k < IO_TIMEOUT; k++) begin
            if (k == dly) begin
                push(o_done, 1'b1);
                return;
            end
            push(o_wait);
        end
        m_err    = 1'b1;
        m_halted = 1'b1;
    endtask

    task automatic expand(input logic [7:0] ins, input logic z, input int dly);
        logic [3:0] op, onehot;
        logic [1:0] src, dst;
        outs_t      o, od;
        op     = ins[7:4];
        src    = ins[3:2];
        dst    = ins[1:0];
        onehot = 4'b0001 << dst;

        o = base(); o.bus1 = B1_PC; o.bus2 = B2_BUS1; o.load_add_r = 1'b1;
        push(o, 1'b0, 1'b1, ins, z);
        o = base(); o.bus2 = B2_MEM; o.load_ir = 1'b1; o.inc_pc = 1'b1;
        push(o);

        o = base();
        if (op == 4'h0) begin
            push(o);
        end else if (op inside {4'h1, 4'h2, 4'h3}) begin
            o.bus1 = {1'b0, src}; o.bus2 = B2_BUS1; o.load_reg_y = 1'b1;
            push(o);
            o = base(); o.bus1 = {1'b0, dst}; o.bus2 = B2_ALU;
            o.load_reg = onehot; o.load_reg_z = 1'b1;
            push(o);
        end else if (op == 4'h4) begin
            o.bus1 = {1'b0, src}; o.bus2 = B2_ALU; o.load_reg = onehot; o.load_reg_z = 1'b1;
            push(o);
        end else if (op == 4'h8 && !z) begin
            o.inc_pc = 1'b1;
            push(o);
        end else if (op inside {4'h5, 4'h6, 4'h7, 4'h8}) begin
            o.bus1 = B1_PC; o.bus2 = B2_BUS1; o.load_add_r = 1'b1;
            push(o);
            o = base(); o.bus2 = B2_MEM; o.load_add_r = 1'b1;
            o.inc_pc = (op == 4'h5 || op == 4'h6);
            push(o);
            o = base();
            if (op == 4'h5) begin
                if (!src[1]) begin
                    o.bus2 = B2_MEM; o.load_reg = onehot;
                    push(o);
                end else begin
                    o.bus2 = B2_IO; o.io_req = 1'b1;
                    od = o; od.load_reg = onehot;
                    io_phase(o, od, dly);
                end
            end else if (op == 4'h6) begin
                o.bus1 = {1'b0, src};
                if (!dst[1]) begin
                    o.mem_write = 1'b1;
                    push(o);
                end else begin
                    o.io_req = 1'b1; o.io_write = 1'b1;
                    io_phase(o, o, dly);
                end
            end else begin
                o.bus2 = B2_MEM; o.load_pc = 1'b1;
                push(o);
            end
        end else if (op == 4'hF) begin
            push(o);
            m_halted = 1'b1;
        end else begin
            push(o);
            m_err    = 1'b1;
            m_halted = 1'b1;
        end
    endtask

    // Plays queued entries; limit < 0 plays the whole queue.
    task automatic run_q(input int limit);
        ent_t e;
        int   n;
        n = 0;
        while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            io_ack = e.ack;
            if (e.drive) begin
                instr = e.instr;
                zero  = e.zero;
            end
            @(negedge clk);
            check($sformatf("cyc i%02h n%0d", cur_instr, n), 32'(act), 32'(e.outs));
            n++;
        end
    endtask

    task automatic finish_reset();
        repeat (3) @(posedge clk);
        check("in_reset", 32'(act), 32'd0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("idle", 32'(act), 32'd0);
        m_err    = 1'b0;
        m_halted = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        io_ack = 1'b0;
        #1;
        check("rst_async", 32'(act), 32'd0);
        finish_reset();
    endtask

    task automatic exec(input logic [7:0] ins, input logic z, input int dly);
        cur_instr = ins;
        exp_q.delete();
        expand(ins, z, dly);
        if (m_halted) begin
            // HALT must ignore whatever instr/zero/io_ack do.
            for (int i = 0; i < 4; i++)
                push(base(), 1'($urandom), 1'b1, 8'($urandom), 1'($urandom));
        end
        run_q(-1);
        if (m_halted)
            do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        finish_reset();

        exec(8'b0001_10_11, 1'b0, 0);     // ADD
        exec(8'b0101_10_01, 1'b0, 3);     // RD from I/O, ack after 3 waits
        exec(8'b0101_00_10, 1'b0, 0);     // RD from memory
        exec(8'b0110_01_00, 1'b0, 0);     // WR to memory
        exec(8'b0100_01_10, 1'b0, 0);     // NOT
        exec(8'b1000_00_00, 1'b0, 0);     // BRZ not taken
        exec(8'b1000_00_00, 1'b1, 0);     // BRZ taken
        exec(8'b0111_00_00, 1'b0, 0);     // BR
        exec(8'b0101_11_00, 1'b0, 15);    // RD I/O, ack in the expiry cycle
        exec(8'b0110_11_10, 1'b0, 1000);  // WR I/O, never acked -> timeout
        exec(8'b1010_00_00, 1'b0, 0);     // illegal opcode
        exec(8'b1111_00_00, 1'b0, 0);     // HLT

        // Reset while an I/O write is waiting: io_req must drop at once.
        cur_instr = 8'b0110_11_10;
        exp_q.delete();
        expand(cur_instr, 1'b0, 1000);
        run_q(6);
        rst = 1'b0;
        #1;
        check("rst_mid_io", 32'(act), 32'd0);
        finish_reset();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0)
                op = 4'($urandom_range(0, 15));
            else
                op = 4'($urandom_range(0, 8));
            exec({op, 4'($urandom)}, 1'($urandom), int'($urandom_range(0, 20)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
